// File: rtl/nibble_sub_pkg.sv
// nibble_sub_pkg: shared state encoding, slice width and nibble-count helper
package nibble_sub_pkg;
   typedef enum logic [0:0] {IDLE, RUN} state_t;
   localparam int NIB = 4;
   function automatic int nibbles(input int width);
      return width / NIB;
   endfunction
endpackage

// File: rtl/nibble_sub_slice.sv
// nibble_sub_slice: combinational 4-bit subtract slice, {bo, d} = a - b - bi
module nibble_sub_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bi,
   output logic [3:0] d,
   output logic       bo
);
   // a five-bit difference goes negative exactly when a < b + bi, so bit 4 is the borrow
   always_comb {bo, d} = {1'b0, a} - {1'b0, b} - {4'b0, bi};
endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: WIDTH-bit subtractor built from one 4-bit slice, one nibble per clock
module nibble_serial_sub
   import nibble_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   localparam int NIBBLES = nibbles(WIDTH);
   localparam int CNT_W = $clog2(NIBBLES);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q, b_q, work, work_nxt;
   logic borrow, bo, last;
   logic [NIB-1:0] d;
   nibble_sub_slice u_slice (
      .a  (a_q[cnt*NIB +: NIB]),
      .b  (b_q[cnt*NIB +: NIB]),
      .bi (borrow),
      .d  (d),
      .bo (bo)
   );
   assign busy = (state == RUN);
   assign last = (cnt == CNT_W'(NIBBLES - 1));
   // working result with the current slice nibble merged in, so the final cycle can publish it whole
   always_comb begin
      work_nxt = work;
      work_nxt[cnt*NIB +: NIB] = d;
   end
   // handshake FSM, ripple borrow register and result register; diff/bout change only on completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         work   <= '0;
         borrow <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_q    <= a;
               b_q    <= b;
               borrow <= bin;
               cnt    <= '0;
               state  <= RUN;
            end
         end else begin
            work   <= work_nxt;
            borrow <= bo;
            cnt    <= cnt + 1'b1;
            if (last) begin
               diff  <= work_nxt;
               bout  <= bo;
               done  <= 1'b1;
               state <= IDLE;
            end
         end
      end
   end
endmodule
